// File: rtl/noc_switch_allocator_pkg.sv
// Shared constants and helpers for the NoC output-port switch allocator.
package noc_switch_allocator_pkg;

  localparam int Noc_Ports      = 5;
  localparam int Noc_VC_Channel = 2;
  localparam int Noc_Credits    = 4;

  typedef logic [Noc_Ports-1:0] port_onehot_t;

  // Index width that stays at least one bit for single-entry structures.
  function automatic int rr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/noc_switch_allocator_if.sv
// Request/grant/route bundle between input VC buffers and one output's allocator.
interface noc_switch_allocator_if
  import noc_switch_allocator_pkg::*;
#(
  parameter int PORTS    = Noc_Ports,
  parameter int CHANNELS = Noc_VC_Channel,
  parameter int CREDITS  = Noc_Credits
);
  localparam int CW = $clog2(CREDITS + 1);

  logic [PORTS-1:0][CHANNELS-1:0]  sop_i;
  logic [PORTS-1:0][CHANNELS-1:0]  eop_i;
  logic [PORTS-1:0][CHANNELS-1:0]  req_i;
  logic [PORTS-1:0][CHANNELS-1:0]  grant_o;
  logic [CHANNELS-1:0]             credit_return_i;
  logic [CHANNELS-1:0][PORTS-1:0]  lock_o;
  logic [CHANNELS-1:0][PORTS-1:0]  route_o;
  logic [CHANNELS-1:0]             route_valid_o;
  logic [CHANNELS-1:0]             route_pop_i;
  logic [CHANNELS-1:0][CW-1:0]     credit_o;
  logic [CHANNELS-1:0]             wdog_err_o;

  modport master (
    output sop_i, eop_i, req_i, credit_return_i, route_pop_i,
    input  grant_o, lock_o, route_o, route_valid_o, credit_o, wdog_err_o
  );

  modport slave (
    input  sop_i, eop_i, req_i, credit_return_i, route_pop_i,
    output grant_o, lock_o, route_o, route_valid_o, credit_o, wdog_err_o
  );

endinterface

// File: rtl/noc_switch_allocator_rr_lock_arbiter.sv
// Round-robin arbiter: search starts at the pointer; the pointer moves past the
// winner only when advance is high, so a held winner keeps priority.
module noc_rr_lock_arbiter
  import noc_switch_allocator_pkg::*;
#(
  parameter int REQUESTS = 4
)(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [REQUESTS-1:0] req,
  input  logic                advance,
  output logic [REQUESTS-1:0] grant
);
  localparam int PW = rr_width(REQUESTS);

  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] ptr_next;
  logic [PW-1:0] win_idx;
  logic          found;

  always_comb begin
    int idx;
    grant   = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < REQUESTS; i++) begin
      idx = int'(ptr_reg) + i;
      if (idx >= REQUESTS) idx = idx - REQUESTS;
      if (!found && req[idx]) begin
        found   = 1'b1;
        win_idx = PW'(idx);
      end
    end
    if (found) grant[win_idx] = 1'b1;
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (found && advance)
      ptr_next = (win_idx == PW'(REQUESTS - 1)) ? '0 : win_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_reg <= '0;
    else        ptr_reg <= ptr_next;
  end

endmodule

// File: rtl/noc_switch_allocator.sv
// Two-stage switch allocator for one router output: packet lock, credit-gated
// flit grant and per-channel route FIFO. Optional lock watchdog: NOC_ALLOC_WATCHDOG_EN.
module noc_switch_allocator
  import noc_switch_allocator_pkg::*;
#(
  parameter int PORTS       = Noc_Ports,
  parameter int CHANNELS    = Noc_VC_Channel,
  parameter int CREDITS     = Noc_Credits,
  parameter int ROUTE_DEPTH = 2,
  parameter int WDOG_CYCLES = 256
)(
  input  logic                  noc_clk,
  input  logic                  noc_rst_n,
  noc_switch_allocator_if.slave bus
);
  localparam int CW = $clog2(CREDITS + 1);
  localparam int AW = rr_width(ROUTE_DEPTH);
  localparam int FW = $clog2(ROUTE_DEPTH + 1);

  logic [CHANNELS-1:0][PORTS-1:0] lock_all;
  logic [CHANNELS-1:0][PORTS-1:0] lock_win;
  logic [CHANNELS-1:0][PORTS-1:0] lock_req;
  logic [CHANNELS-1:0][CW-1:0]    credit_all;
  logic [PORTS-1:0][CHANNELS-1:0] grant;
  logic [CHANNELS-1:0]            granted;
  logic [CHANNELS-1:0]            release_c;
  logic [CHANNELS-1:0]            wdog_clear;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    logic [PORTS-1:0] col_grant, col_eop, col_sop;
    logic [PORTS-1:0] lock_reg;
    logic [CW-1:0]    credit_reg;
    logic [PORTS-1:0] fifo_mem [ROUTE_DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [FW-1:0]    count_reg;
    logic             push, pop, full, eval;

    for (genvar gj = 0; gj < PORTS; gj++) begin : g_col
      assign col_grant[gj] = grant[gj][gi];
      assign col_eop[gj]   = bus.eop_i[gj][gi];
      assign col_sop[gj]   = bus.sop_i[gj][gi];
    end

    assign granted[gi]   = |col_grant;
    assign release_c[gi] = |(col_grant & col_eop);
    assign pop  = bus.route_pop_i[gi] && (count_reg != '0);
    assign full = (count_reg == FW'(ROUTE_DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO only blocks without one.
    assign eval = ((lock_reg == '0) || release_c[gi]) && (!full || pop);
    assign lock_req[gi] = eval ? (col_sop & ~lock_reg) : '0;
    assign push = |lock_win[gi];

    noc_rr_lock_arbiter #(.REQUESTS(PORTS)) u_lock_arb (
      .clk     (noc_clk),
      .rst_n   (noc_rst_n),
      .req     (lock_req[gi]),
      .advance (1'b1),
      .grant   (lock_win[gi])
    );

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n)                       lock_reg <= '0;
      else if (push)                        lock_reg <= lock_win[gi];
      else if (release_c[gi] || wdog_clear[gi]) lock_reg <= '0;
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n)
        credit_reg <= CW'(CREDITS);
      else if (granted[gi] && !bus.credit_return_i[gi])
        credit_reg <= credit_reg - 1'b1;
      else if (bus.credit_return_i[gi] && !granted[gi] && credit_reg != CW'(CREDITS))
        credit_reg <= credit_reg + 1'b1;
    end

    always_ff @(posedge noc_clk) begin
      if (push) fifo_mem[wr_ptr_reg] <= lock_win[gi];
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= (wr_ptr_reg == AW'(ROUTE_DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
        if (pop)  rd_ptr_reg <= (rd_ptr_reg == AW'(ROUTE_DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
        if (push && !pop)      count_reg <= count_reg + 1'b1;
        else if (pop && !push) count_reg <= count_reg - 1'b1;
      end
    end

`ifdef NOC_ALLOC_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    logic [WW-1:0] stall_reg;
    logic          err_reg;

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n) begin
        stall_reg <= '0;
        err_reg   <= 1'b0;
      end else begin
        if (lock_reg == '0 || granted[gi]) stall_reg <= '0;
        else if (stall_reg != WW'(WDOG_CYCLES)) stall_reg <= stall_reg + 1'b1;
        if (wdog_clear[gi]) err_reg <= 1'b1;
      end
    end

    assign wdog_clear[gi]     = (stall_reg == WW'(WDOG_CYCLES)) && (lock_reg != '0);
    assign bus.wdog_err_o[gi] = err_reg;
`else
    assign wdog_clear[gi]     = 1'b0;
    assign bus.wdog_err_o[gi] = 1'b0;
`endif

    assign lock_all[gi]          = lock_reg;
    assign credit_all[gi]        = credit_reg;
    assign bus.lock_o[gi]        = lock_reg;
    assign bus.credit_o[gi]      = credit_reg;
    assign bus.route_valid_o[gi] = (count_reg != '0);
    assign bus.route_o[gi]       = (count_reg != '0) ? fifo_mem[rd_ptr_reg] : '0;
  end

  // Flit stage: the VC pointer only moves when the granted packet ends, keeping grants sticky.
  for (genvar gj = 0; gj < PORTS; gj++) begin : g_port
    logic [CHANNELS-1:0] cand, gnt;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_cand
      assign cand[gi] = lock_all[gi][gj] && bus.req_i[gj][gi] && (credit_all[gi] != '0);
    end

    noc_rr_lock_arbiter #(.REQUESTS(CHANNELS)) u_flit_arb (
      .clk     (noc_clk),
      .rst_n   (noc_rst_n),
      .req     (cand),
      .advance (|(gnt & bus.eop_i[gj])),
      .grant   (gnt)
    );

    assign grant[gj]       = gnt;
    assign bus.grant_o[gj] = gnt;
  end

endmodule

// File: tb/tb_noc_switch_allocator.sv
// Directed self-checking bench for noc_switch_allocator (lock, credit, route FIFO,
// multi-VC stickiness, async reset, and watchdog when NOC_ALLOC_WATCHDOG_EN is set).
module tb_noc_switch_allocator;
  import noc_switch_allocator_pkg::*;

  localparam int PORTS       = 5;
  localparam int CHANNELS    = 2;
  localparam int CREDITS     = 4;
  localparam int ROUTE_DEPTH = 2;
  localparam int WDOG_CYCLES = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  noc_switch_allocator_if #(.PORTS(PORTS), .CHANNELS(CHANNELS), .CREDITS(CREDITS)) bus ();

  noc_switch_allocator #(
    .PORTS(PORTS), .CHANNELS(CHANNELS), .CREDITS(CREDITS),
    .ROUTE_DEPTH(ROUTE_DEPTH), .WDOG_CYCLES(WDOG_CYCLES)
  ) dut (
    .noc_clk   (clk),
    .noc_rst_n (rst_n),
    .bus       (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    $display("[TB] %s obs=%0h exp=%0h", tag, obs, exp);
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.sop_i           = '0;
    bus.eop_i           = '0;
    bus.req_i           = '0;
    bus.credit_return_i = '0;
    bus.route_pop_i     = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    port_onehot_t p1 = 5'b00010;
    port_onehot_t p3 = 5'b01000;

    // Reset state
    do_reset();
    check("rst lock",        bus.lock_o,        '0);
    check("rst credit0",     bus.credit_o[0],   4);
    check("rst credit1",     bus.credit_o[1],   4);
    check("rst route_valid", bus.route_valid_o, '0);
    check("rst route",       bus.route_o,       '0);
    check("rst wdog",        bus.wdog_err_o,    '0);
    check("rst grant",       bus.grant_o,       '0);

    // Ports 1 and 3 contend for channel 0; back-to-back lock handover
    bus.sop_i[1][0] = 1'b1; bus.req_i[1][0] = 1'b1;
    bus.sop_i[3][0] = 1'b1; bus.req_i[3][0] = 1'b1;
    #1 check("t1 c0 grant", bus.grant_o, '0);
    tick();
    check("t1 c1 lock",        bus.lock_o[0],        p1);
    check("t1 c1 route_valid", bus.route_valid_o[0], 1);
    check("t1 c1 route",       bus.route_o[0],       p1);
    check("t1 c1 grant p1",    bus.grant_o[1][0],    1);
    check("t1 c1 grant p3",    bus.grant_o[3][0],    0);
    tick();
    bus.sop_i[1][0] = 1'b0; bus.eop_i[1][0] = 1'b1;
    #1 check("t1 c2 tail grant", bus.grant_o[1][0], 1);
    tick();
    check("t1 c3 lock p3",  bus.lock_o[0],   p3);
    check("t1 c3 credit",   bus.credit_o[0], 2);
    check("t1 c3 route",    bus.route_o[0],  p1);
    bus.req_i[1][0] = 1'b0; bus.eop_i[1][0] = 1'b0;
    bus.eop_i[3][0] = 1'b1;
    bus.credit_return_i[0] = 1'b1;
    bus.route_pop_i[0] = 1'b1;
    #1 check("t1 c3 grant p3", bus.grant_o[3][0], 1);
    tick();
    check("t1 c4 credit grant+return", bus.credit_o[0],      2);
    check("t1 c4 unlocked",            bus.lock_o[0],        '0);
    check("t1 c4 route",               bus.route_o[0],       p3);
    check("t1 c4 route_valid",         bus.route_valid_o[0], 1);
    bus.sop_i[3][0] = 1'b0; bus.req_i[3][0] = 1'b0; bus.eop_i[3][0] = 1'b0;
    bus.credit_return_i[0] = 1'b0;
    tick();
    check("t1 c5 route_valid", bus.route_valid_o[0], 0);
    check("t1 c5 route",       bus.route_o[0],       '0);

    // Credit exhaustion on a 6-flit packet
    do_reset();
    bus.sop_i[0][0] = 1'b1; bus.req_i[0][0] = 1'b1;
    tick();
    check("t2 lock", bus.lock_o[0], 5'b00001);
    bus.sop_i[0][0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1 check($sformatf("t2 grant flit%0d", k + 1), bus.grant_o[0][0], 1);
      tick();
    end
    check("t2 credit empty", bus.credit_o[0],    0);
    check("t2 grant gated",  bus.grant_o[0][0],  0);
    bus.credit_return_i[0] = 1'b1;
    #1 check("t2 grant during return", bus.grant_o[0][0], 0);
    tick();
    bus.credit_return_i[0] = 1'b0;
    check("t2 credit one", bus.credit_o[0], 1);
    #1 check("t2 grant flit5", bus.grant_o[0][0], 1);
    tick();
    check("t2 credit spent", bus.credit_o[0],   0);
    check("t2 grant stop",   bus.grant_o[0][0], 0);

    // Route FIFO full blocks the third lock until a pop
    do_reset();
    for (int p = 0; p < 3; p++) begin
      bus.sop_i[p][0] = 1'b1; bus.req_i[p][0] = 1'b1; bus.eop_i[p][0] = 1'b1;
    end
    tick();
    check("t3 c1 lock p0",  bus.lock_o[0],     5'b00001);
    check("t3 c1 grant p0", bus.grant_o[0][0], 1);
    tick();
    bus.sop_i[0][0] = 1'b0; bus.req_i[0][0] = 1'b0; bus.eop_i[0][0] = 1'b0;
    check("t3 c2 lock p1", bus.lock_o[0], 5'b00010);
    tick();
    bus.sop_i[1][0] = 1'b0; bus.req_i[1][0] = 1'b0; bus.eop_i[1][0] = 1'b0;
    check("t3 c3 blocked",     bus.lock_o[0],        '0);
    check("t3 c3 route_valid", bus.route_valid_o[0], 1);
    tick();
    check("t3 c4 blocked", bus.lock_o[0], '0);
    bus.route_pop_i[0] = 1'b1;
    tick();
    bus.route_pop_i[0] = 1'b0;
    check("t3 c5 lock p2", bus.lock_o[0],  5'b00100);
    check("t3 c5 route",   bus.route_o[0], 5'b00010);

    // One port holding two channels: one grant per cycle, sticky per packet
    do_reset();
    bus.sop_i[2][0] = 1'b1; bus.req_i[2][0] = 1'b1;
    bus.sop_i[2][1] = 1'b1; bus.req_i[2][1] = 1'b1;
    tick();
    check("t4 c1 lock ch0", bus.lock_o[0], 5'b00100);
    check("t4 c1 lock ch1", bus.lock_o[1], 5'b00100);
    bus.sop_i[2][0] = 1'b0; bus.sop_i[2][1] = 1'b0;
    #1 check("t4 c1 grant", bus.grant_o[2], 2'b01);
    tick();
    bus.eop_i[2][0] = 1'b1;
    #1 check("t4 c2 grant", bus.grant_o[2], 2'b01);
    tick();
    check("t4 c3 ch0 released", bus.lock_o[0], '0);
    bus.eop_i[2][0] = 1'b0;
    bus.sop_i[2][0] = 1'b1; bus.req_i[2][0] = 1'b1;
    #1 check("t4 c3 grant", bus.grant_o[2], 2'b10);
    tick();
    check("t4 c4 ch0 relocked", bus.lock_o[0], 5'b00100);
    bus.sop_i[2][0] = 1'b0;
    #1 check("t4 c4 grant sticky", bus.grant_o[2], 2'b10);
    check("t4 c4 credit0", bus.credit_o[0], 2);
    check("t4 c4 credit1", bus.credit_o[1], 3);
    rst_n = 1'b0;
    #1;
    check("t4 midrst lock",        bus.lock_o,        '0);
    check("t4 midrst credit0",     bus.credit_o[0],   4);
    check("t4 midrst credit1",     bus.credit_o[1],   4);
    check("t4 midrst route_valid", bus.route_valid_o, '0);
    clear_inputs();
    tick();
    rst_n = 1'b1;

    // Stalled lock: watchdog force-clear, or persistent lock without it
    do_reset();
    bus.sop_i[4][1] = 1'b1;
    tick();
    check("t5 lock", bus.lock_o[1], 5'b10000);
    bus.sop_i[4][1] = 1'b0;
`ifdef NOC_ALLOC_WATCHDOG_EN
    repeat (8) tick();
    check("t5 c9 still locked", bus.lock_o[1],    5'b10000);
    check("t5 c9 no err",       bus.wdog_err_o,   '0);
    tick();
    check("t5 c10 cleared",     bus.lock_o[1],    '0);
    check("t5 c10 err",         bus.wdog_err_o,   2'b10);
    check("t5 c10 route kept",  bus.route_valid_o[1], 1);
    repeat (5) tick();
    check("t5 err sticky",      bus.wdog_err_o,   2'b10);
    do_reset();
    check("t5 err reset",       bus.wdog_err_o,   '0);
`else
    repeat (12) tick();
    check("t5 lock persists", bus.lock_o[1],  5'b10000);
    check("t5 no err",        bus.wdog_err_o, '0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
